// File: rtl/sum_collector_pkg.sv
// sum_collector_pkg: shared types for the sum result collector and its FIFO.
package sum_collector_pkg;
  localparam int SUM_W = 5;
  typedef logic [SUM_W-1:0] sum_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;
endpackage

// File: rtl/sum_fifo.sv
// sum_fifo: synchronous FIFO with occupancy-driven EMPTY/PARTIAL/FULL state.
module sum_fifo
  import sum_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = sum_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_ready,
  input  T              i_data,
  output T              o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [CW-1:0] o_count
);
  T              r_mem [DEPTH];
  logic [AW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;
  fifo_state_e   r_state;
  logic          w_pop;
  logic [CW-1:0] w_next;
  assign w_pop  = o_valid & i_ready;
  assign w_next = r_count + CW'(i_push) - CW'(w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_state <= EMPTY;
    end else begin
      r_rptr  <= r_rptr + AW'(w_pop);
      r_wptr  <= r_wptr + AW'(i_push);
      r_count <= w_next;
      r_state <= (w_next == '0) ? EMPTY : (w_next == CW'(DEPTH)) ? FULL : PARTIAL;
    end
  end
  // Storage is deliberately left unreset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end
  assign o_valid = r_state != EMPTY;
  assign o_full  = r_state == FULL;
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/sum_result_collector.sv
// sum_result_collector: captures one adder sum per done rising edge into a FIFO.
// Optional running total/count enabled by SUM_RESULT_COLLECTOR_ACC_EN.
module sum_result_collector
  import sum_collector_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
  , parameter int ACC_W = 12
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  sum_t                           s,
  input  logic                           done,
  input  logic                           out_ready,
  input  logic                           ovf_clr,
  output logic                           out_valid,
  output sum_t                           out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
  , output logic [ACC_W-1:0]             acc_total
  , output logic [7:0]                   acc_cnt
`endif
);
  logic r_done_q, r_overflow;
  logic w_cap, w_full, w_push, w_drop;
  assign w_cap  = done & ~r_done_q;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = w_cap & (~w_full | (out_valid & out_ready));
  assign w_drop = w_cap & ~w_push;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done_q   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q   <= done;
      r_overflow <= w_drop | (r_overflow & ~ovf_clr);
    end
  end
  assign overflow = r_overflow;
  sum_fifo #(.DEPTH(DEPTH), .T(sum_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_ready (out_ready),
    .i_data  (s),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_count (count)
  );
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
  logic [ACC_W-1:0] r_acc_total;
  logic [7:0]       r_acc_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_total <= '0;
      r_acc_cnt   <= '0;
    end else if (w_push) begin
      r_acc_total <= r_acc_total + ACC_W'(s);
      r_acc_cnt   <= r_acc_cnt + 8'd1;
    end
  end
  assign acc_total = r_acc_total;
  assign acc_cnt   = r_acc_cnt;
`endif
endmodule

// File: tb/tb_sum_result_collector.sv
// tb_sum_result_collector: directed plan plus random traffic against a queue model.
module tb_sum_result_collector;
  localparam int DEPTH = 4;
  logic       clk = 0, rst_n = 0, done = 0, out_ready = 0, ovf_clr = 0;
  logic [4:0] s = 0;
  logic       out_valid, overflow;
  logic [4:0] out_data;
  logic [2:0] count;
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
  logic [11:0] acc_total;
  logic [7:0]  acc_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  int q[$];
  int dut_pop[$];
  bit m_dq, m_ovf;
  int m_acc, m_cnt;
  always #5 clk = ~clk;
  sum_result_collector #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .done      (done),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
    , .acc_total (acc_total)
    , .acc_cnt   (acc_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    bit cap, pop, drop;
    if (rst_n && out_valid && out_ready) dut_pop.push_back(int'(out_data));
    if (!rst_n) begin
      q.delete();
      m_dq = 0; m_ovf = 0; m_acc = 0; m_cnt = 0;
    end else begin
      cap  = done && !m_dq;
      pop  = q.size() > 0 && out_ready;
      drop = 0;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) begin
          q.push_back(int'(s));
          m_acc = (m_acc + int'(s)) % 4096;
          m_cnt = (m_cnt + 1) % 256;
        end else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_dq = done;
    end
    @(posedge clk);
    #1;
    check("model_count", 32'(count), 32'(q.size()));
    check("model_valid", 32'(out_valid), 32'(q.size() > 0));
    check("model_data", 32'(out_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check("model_ovf", 32'(overflow), 32'(m_ovf));
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
    check("model_acc_total", 32'(acc_total), 32'(m_acc));
    check("model_acc_cnt", 32'(acc_cnt), 32'(m_cnt));
`endif
  endtask
  task automatic cyc(input bit rn, input bit d, input int sv, input bit r, input bit c);
    rst_n = rn; done = d; s = 5'(sv); out_ready = r; ovf_clr = c;
    step();
  endtask
  initial begin
    int exp_ord[6] = '{5, 9, 30, 0, 7, 12};
    int push_vals[4] = '{5, 9, 30, 0};
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    cyc(1, 1, 23, 0, 0);
    check("edge_count", 32'(count), 1);
    check("edge_data", 32'(out_data), 23);
    cyc(1, 1, 23, 0, 0);
    cyc(1, 1, 23, 0, 0);
    check("edge_hold_count", 32'(count), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    check("drain_count", 32'(count), 0);
    dut_pop.delete();
    foreach (push_vals[i]) begin
      cyc(1, 1, push_vals[i], 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    check("fill_count", 32'(count), 4);
    repeat (4) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 12, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 1, 0);
    check("order_len", 32'(dut_pop.size()), 6);
    foreach (exp_ord[i]) check("order_val", i < dut_pop.size() ? 32'(dut_pop[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));
    for (int v = 1; v <= 4; v++) begin
      cyc(1, 1, v, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    cyc(1, 1, 17, 0, 0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    cyc(1, 0, 0, 0, 1);
    check("ovf_clr", 32'(overflow), 0);
    cyc(1, 1, 11, 1, 0);
    check("fullpop_count", 32'(count), 4);
    check("fullpop_ovf", 32'(overflow), 0);
    check("fullpop_head", 32'(out_data), 2);
    cyc(1, 0, 0, 1, 0);
    check("mid_count", 32'(count), 3);
    cyc(0, 1, 19, 0, 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_data", 32'(out_data), 0);
    cyc(1, 0, 0, 0, 0);
    check("midrst_nocap", 32'(count), 0);
`ifdef SUM_RESULT_COLLECTOR_ACC_EN
    repeat (140) begin
      cyc(1, 1, 30, 1, 0);
      cyc(1, 0, 0, 1, 0);
    end
    check("acc_total", 32'(acc_total), 104);
    check("acc_cnt", 32'(acc_cnt), 140);
`endif
    repeat (400) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 31)),
          $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
